// File: rtl/count_ctrl_pkg.sv
// Shared definitions for the count_ctrl run/pause/finish controller:
// FSM state encodings and the packed 3-digit BCD layout.
package count_ctrl_pkg;

    localparam int BCD_W = 12;

    // Digit fields of the packed BCD counter value
    localparam int HUND_MSB = 11;
    localparam int HUND_LSB = 8;
    localparam int TENS_MSB = 7;
    localparam int TENS_LSB = 4;
    localparam int ONES_MSB = 3;
    localparam int ONES_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/count_ctrl_tick_gen.sv
// Prescaler for the count-enable strobe: counts 0..TICK_DIV-1 while running
// and flags the wrap cycle; a synchronous restart returns it to 0.
module tick_gen #(
    parameter int TICK_DIV = 100_000_000,
    parameter int TICK_W   = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    input  logic i_run,
    output logic o_tick
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + TICK_W'(1);
        end
    end

    // Wrap indication; the owner registers it into the outgoing strobe
    assign o_tick = i_run && !i_restart && (r_cnt == LAST);

endmodule

// File: rtl/count_ctrl.sv
// Run/pause/finish controller for the 3-digit BCD counter. Optional lap
// capture on the display path is built only when CTRL_LAP_EN is defined.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int TICK_W   = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
`ifdef CTRL_LAP_EN
    input  logic             lap,
`endif
    input  logic [BCD_W-1:0] target_bcd,
    input  logic [BCD_W-1:0] cnt_bcd,
    input  logic             cnt_done,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             running,
    output logic             done,
    output logic [1:0]       state,
    output logic [BCD_W-1:0] disp_bcd
);

    state_t r_state;
    state_t w_next;
    logic   r_cnt_en;
    logic   r_cnt_clr;
    logic   r_running;
    logic   r_done;
    logic   w_hit;
    logic   w_tick;
    logic   w_enter_run;

    // A non-BCD target digit can never match, leaving cnt_done as the only stop
    assign w_hit = ((cnt_bcd[HUND_MSB:HUND_LSB] == target_bcd[HUND_MSB:HUND_LSB]) &&
                    (cnt_bcd[TENS_MSB:TENS_LSB] == target_bcd[TENS_MSB:TENS_LSB]) &&
                    (cnt_bcd[ONES_MSB:ONES_LSB] == target_bcd[ONES_MSB:ONES_LSB])) ||
                   cnt_done;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (clear)      w_next = ST_IDLE;
                else if (start) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (clear)      w_next = ST_IDLE;
                else if (w_hit) w_next = ST_FINISH;
                else if (stop)  w_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (clear)      w_next = ST_IDLE;
                else if (start) w_next = ST_RUN;
            end
            ST_FINISH: begin
                if (clear)      w_next = ST_IDLE;
            end
        endcase
    end

    assign w_enter_run = (r_state != ST_RUN) && (w_next == ST_RUN);

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_enter_run),
        .i_run     (r_state == ST_RUN),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt_en  <= 1'b0;
            r_cnt_clr <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            // A tick is dropped when the count is about to leave RUN
            r_cnt_en  <= w_tick && !w_hit && (w_next == ST_RUN);
            r_cnt_clr <= clear;
            r_running <= (w_next == ST_RUN);
            r_done    <= (w_next == ST_FINISH);
        end
    end

`ifdef CTRL_LAP_EN
    logic [BCD_W-1:0] r_lap_reg;
    logic             r_lap_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lap_reg  <= '0;
            r_lap_hold <= 1'b0;
        end else if (clear) begin
            r_lap_hold <= 1'b0;
        end else if (lap && ((r_state == ST_RUN) || (r_state == ST_PAUSE))) begin
            if (r_lap_hold) begin
                r_lap_hold <= 1'b0;
            end else begin
                r_lap_reg  <= cnt_bcd;
                r_lap_hold <= 1'b1;
            end
        end
    end

    assign disp_bcd = r_lap_hold ? r_lap_reg : cnt_bcd;
`else
    assign disp_bcd = cnt_bcd;
`endif

    assign cnt_en  = r_cnt_en;
    assign cnt_clr = r_cnt_clr;
    assign running = r_running;
    assign done    = r_done;
    assign state   = r_state;

endmodule
